// File: rtl/mem_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_controller_pkg
// Description : Shared sizes, types and helpers for the packet buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_controller_pkg;

  localparam int DATA_W    = 32;
  localparam int ID_W      = 4;
  localparam int NUM_PKTS  = 2 ** ID_W;
  localparam int MAX_WORDS = 64;
  localparam int PTR_W     = $clog2(MAX_WORDS);
  localparam int LEN_W     = PTR_W + 1;          // must hold the value MAX_WORDS
  localparam int ADDR_W    = ID_W + PTR_W;
  localparam int BE_W      = DATA_W / 8;

  typedef logic [ID_W-1:0]   pkt_id_t;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [LEN_W-1:0]  len_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DROP  = 2'd2
  } wr_state_e;

  // Lowest set bit of free_vec; returns 0 when nothing is set (callers check).
  function automatic pkt_id_t lowest_free(input logic [NUM_PKTS-1:0] free_vec);
    pkt_id_t id;
    id = '0;
    for (int i = NUM_PKTS - 1; i >= 0; i--) begin
      if (free_vec[i]) id = pkt_id_t'(i);
    end
    return id;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_controller_if
// Description : Ingress write stream and parser read-side signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_controller_if;
  import mem_controller_pkg::*;

  word_t             data_in;
  logic [BE_W-1:0]   byte_valid;
  logic              wen;
  logic              w_last_pkt;
  pkt_id_t           id_out;
  logic              ren;
  pkt_id_t           r_id_in;
  word_t             data_out;
  logic              r_last_pkt;

  modport slave (
    input  data_in, byte_valid, wen, w_last_pkt, ren, r_id_in,
    output id_out, data_out, r_last_pkt
  );

  modport master (
    output data_in, byte_valid, wen, w_last_pkt, ren, r_id_in,
    input  id_out, data_out, r_last_pkt
  );

endinterface
`default_nettype wire

// File: rtl/mem_controller_pkt_ram.sv
`default_nettype none
// ============================================================================
// Module      : mem_controller_pkt_ram
// Description : Simple dual-port packet RAM, one write port and one read
//               port with a registered output.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_controller_pkt_ram
  import mem_controller_pkg::*;
(
  input  logic  clk_i,
  input  logic  we_i,
  input  addr_t waddr_i,
  input  word_t wdata_i,
  input  logic  re_i,
  input  addr_t raddr_i,
  output word_t rdata_o
);

  word_t mem_q [NUM_PKTS*MAX_WORDS];
  word_t rdata_q;

  // Write port
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read port, output register only updates on an enabled read
  always_ff @(posedge clk_i) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/mem_controller.sv
`default_nettype none
// ============================================================================
// Module      : mem_controller
// Description : Packet buffer - 16 slots of up to 64 words, written as a
//               stream with slot allocation, read back whole by slot id.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_controller
  import mem_controller_pkg::*;
(
  input  logic            CLK,
  input  logic            reset,
  mem_controller_if.slave bus
);

  // Write side state
  wr_state_e           state_q, state_d;
  pkt_id_t             cur_id_q, cur_id_d;
  ptr_t                wptr_q, wptr_d;
  logic [NUM_PKTS-1:0] valid_q, valid_d;
  len_t                len_q [NUM_PKTS];
  pkt_id_t             id_out_q, id_out_d;

  // Read side state
  ptr_t                rptr_q;
  pkt_id_t             last_rid_q;
  logic                rd_zero_q;   // data_out forced to 0 (reset / miss)
  logic                r_last_q;

  // Combinational helpers
  logic [NUM_PKTS-1:0] excl_vec, free_vec, free_next;
  logic                any_free;
  pkt_id_t             free_id;
  logic                ram_we;
  addr_t               ram_waddr;
  word_t               wdata_masked;
  logic                wr_done;
  len_t                wr_len;
  ptr_t                rd_ptr;
  logic                rd_hit, rd_last;
  addr_t               ram_raddr;
  word_t               ram_rdata;

  // Invalid byte lanes are stored as zero
  for (genvar k = 0; k < BE_W; k++) begin : g_lane
    assign wdata_masked[8*k +: 8] = bus.byte_valid[k] ? bus.data_in[8*k +: 8] : 8'h00;
  end

  // Slot being written is not free even though its valid bit is still clear
  assign excl_vec = (state_q == WRITE) ? (NUM_PKTS'(1) << cur_id_q) : '0;
  assign free_vec = ~valid_q & ~excl_vec;
  assign any_free = |free_vec;
  assign free_id  = lowest_free(free_vec);

  // Write FSM next state, RAM write request and packet completion
  always_comb begin
    state_d   = state_q;
    cur_id_d  = cur_id_q;
    wptr_d    = wptr_q;
    ram_we    = 1'b0;
    ram_waddr = {cur_id_q, wptr_q};
    wr_done   = 1'b0;
    wr_len    = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.wen && any_free) begin
          cur_id_d  = free_id;
          ram_we    = 1'b1;
          ram_waddr = {free_id, ptr_t'(0)};
          if (bus.w_last_pkt) begin
            wr_done = 1'b1;
            wr_len  = len_t'(1);
            wptr_d  = '0;
          end else begin
            wptr_d  = ptr_t'(1);
            state_d = WRITE;
          end
        end else if (bus.wen && !bus.w_last_pkt) begin
          state_d = DROP;
        end
      end
      WRITE: begin
        if (bus.wen) begin
          ram_we = 1'b1;
          // The last slot word closes the packet even without w_last_pkt
          if (bus.w_last_pkt || (wptr_q == ptr_t'(MAX_WORDS - 1))) begin
            wr_done = 1'b1;
            wr_len  = {1'b0, wptr_q} + len_t'(1);
            wptr_d  = '0;
            state_d = bus.w_last_pkt ? IDLE : DROP;
          end else begin
            wptr_d  = wptr_q + ptr_t'(1);
          end
        end
      end
      DROP: begin
        if (bus.wen && bus.w_last_pkt) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read decode; switching to a different id restarts at word 0
  always_comb begin
    rd_ptr    = (bus.r_id_in == last_rid_q) ? rptr_q : '0;
    rd_hit    = bus.ren && valid_q[bus.r_id_in];
    rd_last   = rd_hit && ({1'b0, rd_ptr} == (len_q[bus.r_id_in] - len_t'(1)));
    ram_raddr = {bus.r_id_in, rd_ptr};
  end

  // Next slot occupancy and next id_out
  always_comb begin
    valid_d = valid_q;
    if (wr_done) valid_d[cur_id_d] = 1'b1;
    if (rd_last) valid_d[bus.r_id_in] = 1'b0;
    free_next = ~valid_d;
    if (state_d == WRITE) begin
      id_out_d = cur_id_d;
    end else if (|free_next) begin
      id_out_d = lowest_free(free_next);
    end else begin
      id_out_d = id_out_q;
    end
  end

  // Write FSM and slot bookkeeping registers
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q  <= IDLE;
      cur_id_q <= '0;
      wptr_q   <= '0;
      valid_q  <= '0;
      id_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cur_id_q <= cur_id_d;
      wptr_q   <= wptr_d;
      valid_q  <= valid_d;
      id_out_q <= id_out_d;
    end
  end

  // Packet lengths are only consulted while the slot is valid
  always_ff @(posedge CLK) begin
    if (reset && wr_done) len_q[cur_id_d] <= wr_len;
  end

  // Read pointer and registered read status
  always_ff @(posedge CLK) begin
    if (!reset) begin
      rptr_q     <= '0;
      last_rid_q <= '0;
      rd_zero_q  <= 1'b1;
      r_last_q   <= 1'b0;
    end else if (bus.ren) begin
      if (rd_hit) begin
        rd_zero_q  <= 1'b0;
        r_last_q   <= rd_last;
        rptr_q     <= rd_last ? '0 : rd_ptr + ptr_t'(1);
        last_rid_q <= bus.r_id_in;
      end else begin
        rd_zero_q  <= 1'b1;
        r_last_q   <= 1'b0;
      end
    end
  end

  mem_controller_pkt_ram u_pkt_ram (
    .clk_i   (CLK),
    .we_i    (ram_we && reset),
    .waddr_i (ram_waddr),
    .wdata_i (wdata_masked),
    .re_i    (rd_hit && reset),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  assign bus.id_out     = id_out_q;
  assign bus.data_out   = rd_zero_q ? '0 : ram_rdata;
  assign bus.r_last_pkt = r_last_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_controller
// Description : Scoreboard bench for the packet buffer with a transaction
//               level reference model of slots, packets and reads.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_controller;

  logic clk;
  logic reset;
  mem_controller_if bus ();

  mem_controller dut (
    .CLK   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit active = 1'b0;

  // Scoreboard queues: expected id_out every cycle, expected read word on
  // cycles that issued a read (or reset)
  logic [3:0]  idq [$];
  logic [32:0] rdq [$];

  // Reference model: each slot is a queue of words
  logic [31:0] m_data [16][$];
  bit   [15:0] m_valid;
  logic [31:0] wbuf [$];
  bit          m_inpkt, m_drop;
  int          m_wslot, m_rid, m_rpos;
  int          m_id;

  function automatic logic [31:0] lane_mask(input logic [31:0] d, input logic [3:0] bv);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) if (bv[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  function automatic int first_free(input bit [15:0] v);
    for (int i = 0; i < 16; i++) if (!v[i]) return i;
    return -1;
  endfunction

  // One clock of stimulus; the model predicts the outputs after the edge
  task automatic cyc(input bit rst_n, input bit wen, input bit last,
                     input logic [31:0] d, input logic [3:0] bv,
                     input bit ren, input logic [3:0] rid);
    bit [15:0] pre;
    int set_id, clr_id, f;
    logic [31:0] w;
    bit lst;
    reset          = rst_n;
    bus.wen        = wen;
    bus.w_last_pkt = last;
    bus.data_in    = d;
    bus.byte_valid = bv;
    bus.ren        = ren;
    bus.r_id_in    = rid;
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m_data[i].delete();
      m_valid = '0; wbuf.delete(); m_inpkt = 0; m_drop = 0;
      m_rid = 0; m_rpos = 0; m_id = 0;
      rdq.push_back(33'h0);
      idq.push_back(4'd0);
    end else begin
      pre = m_valid; set_id = -1; clr_id = -1;
      if (wen) begin
        if (m_drop) begin
          if (last) m_drop = 0;
        end else if (!m_inpkt) begin
          f = first_free(pre);
          if (f < 0) begin
            if (!last) m_drop = 1;
          end else begin
            m_wslot = f;
            wbuf.delete();
            wbuf.push_back(lane_mask(d, bv));
            if (last) set_id = f; else m_inpkt = 1;
          end
        end else begin
          wbuf.push_back(lane_mask(d, bv));
          if (last) begin
            set_id = m_wslot; m_inpkt = 0;
          end else if (wbuf.size() == 64) begin
            set_id = m_wslot; m_inpkt = 0; m_drop = 1;
          end
        end
      end
      if (set_id >= 0) m_data[set_id] = wbuf;
      if (ren) begin
        if (pre[rid]) begin
          if (int'(rid) != m_rid) m_rpos = 0;
          m_rid = int'(rid);
          w   = m_data[rid][m_rpos];
          lst = (m_rpos == m_data[rid].size() - 1);
          if (lst) begin clr_id = int'(rid); m_rpos = 0; end
          else m_rpos++;
          rdq.push_back({w, lst});
        end else begin
          rdq.push_back(33'h0);
        end
      end
      if (set_id >= 0) m_valid[set_id] = 1'b1;
      if (clr_id >= 0) m_valid[clr_id] = 1'b0;
      if (m_inpkt) m_id = m_wslot;
      else begin
        f = first_free(m_valid);
        if (f >= 0) m_id = f;
      end
      idq.push_back(4'(m_id));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1, 0, 0, 32'h0, 4'h0, 0, 4'd0);
  endtask
  task automatic rst_cyc();
    cyc(0, 0, 0, 32'h0, 4'h0, 0, 4'd0);
  endtask
  task automatic wr(input logic [31:0] d, input logic [3:0] bv, input bit last);
    cyc(1, 1, last, d, bv, 0, 4'd0);
  endtask
  task automatic rd(input logic [3:0] id);
    cyc(1, 0, 0, 32'h0, 4'h0, 1, id);
  endtask

  // Monitor: sample the cycle's controls at the edge, compare mid-cycle
  initial begin
    bit s_ren, s_rst, s_act;
    logic [3:0]  eid;
    logic [32:0] erd;
    forever begin
      @(posedge clk);
      s_ren = bus.ren; s_rst = reset; s_act = active;
      @(negedge clk);
      if (s_act) begin
        total++;
        if (idq.size() == 0) begin
          bad++;
          $display("FAIL idq_underflow: got empty queue want entry at %0t", $time);
        end else begin
          eid = idq.pop_front();
          if (bus.id_out !== eid) begin
            bad++;
            $display("FAIL id_out: got %0d want %0d at %0t", bus.id_out, eid, $time);
          end
        end
        if (s_ren || !s_rst) begin
          total++;
          if (rdq.size() == 0) begin
            bad++;
            $display("FAIL rdq_underflow: got empty queue want entry at %0t", $time);
          end else begin
            erd = rdq.pop_front();
            if (bus.data_out !== erd[32:1] || bus.r_last_pkt !== erd[0]) begin
              bad++;
              $display("FAIL read: got data=%08h last=%0b want data=%08h last=%0b at %0t",
                       bus.data_out, bus.r_last_pkt, erd[32:1], erd[0], $time);
            end
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; bus.wen = 0; bus.w_last_pkt = 0; bus.data_in = '0;
    bus.byte_valid = '0; bus.ren = 0; bus.r_id_in = '0;
    @(posedge clk); #1;
    active = 1'b1;

    // Empty read while a packet is still being written
    cyc(0, 0, 0, 32'h0, 4'h0, 1, 4'd0);
    rst_cyc();
    wr(32'hDEADFACE, 4'hF, 0);
    cyc(1, 1, 0, 32'hDEADFACE, 4'hF, 1, 4'd0);
    idle();

    // Single packet with a partial last word
    rst_cyc();
    wr(32'h11111111, 4'hF, 0);
    wr(32'h22222222, 4'hF, 0);
    wr(32'h33333333, 4'h3, 1);
    rd(0); rd(0); rd(0); rd(0);
    idle();

    // Allocate all slots, overflow, reuse of slot 5, read everything back
    rst_cyc();
    for (int i = 0; i < 17; i++) wr($urandom, 4'hF, 1);
    rd(5);
    idle();
    wr($urandom, 4'hF, 1);
    for (int i = 0; i < 16; i++) rd(4'(i));
    idle();

    // Overlong packet: 70 words, only 64 kept
    rst_cyc();
    for (int i = 1; i <= 70; i++) wr(32'(i) | 32'hA000_0000, 4'hF, i == 70);
    wr(32'hCAFEF00D, 4'hF, 1);
    for (int i = 0; i < 65; i++) rd(0);
    rd(1);
    idle();

    // Reset in the middle of a write and a read
    rst_cyc();
    for (int i = 0; i < 4; i++) wr($urandom, 4'hF, i == 3);
    rd(0); rd(0);
    cyc(1, 1, 0, 32'h12345678, 4'hF, 1, 4'd0);
    cyc(1, 1, 0, 32'h9ABCDEF0, 4'hF, 0, 4'd0);
    cyc(0, 1, 0, 32'h55555555, 4'hF, 1, 4'd0);
    rd(0); rd(1);
    idle();

    // Randomized traffic with read-id switching and rare resets
    for (int n = 0; n < 1500; n++) begin
      bit r_rst, r_wen, r_last, r_ren;
      r_rst  = ($urandom_range(0, 399) != 0);
      r_wen  = ($urandom_range(0, 2) != 0);
      r_last = ($urandom_range(0, 4) == 0) || ($urandom_range(0, 99) == 0);
      r_ren  = ($urandom_range(0, 1) != 0);
      cyc(r_rst, r_wen, r_last, $urandom, 4'($urandom), r_ren, 4'($urandom_range(0, 5)));
    end
    idle();

    @(negedge clk); #1;
    active = 1'b0;
    total++;
    if (idq.size() != 0 || rdq.size() != 0) begin
      bad++;
      $display("FAIL leftover: got id=%0d rd=%0d want 0 0", idq.size(), rdq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
